combo_lock_core: RTL and testbench
==================================

COMBO_LOCK_CORE -- requirements
Module: combo_lock_core

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of CLK.
REQ-002 Parameter NUM_DIALS, default 3, SHALL set the number of dials (1..8).
REQ-003 Parameter DIAL_W, default 5, SHALL set the bit width of each dial value.
REQ-004 Parameter DIAL_MAX, default 19, SHALL set the highest dial value (DIAL_MAX < 2^DIAL_W).
REQ-005 Parameter MAX_TRIES, default 3, SHALL set the number of failed attempts that triggers lockout (1..15).
REQ-006 Parameter LOCKOUT_CYCLES, default 16, SHALL set the lockout duration in clock cycles (>=1).
REQ-007 The ports SHALL be:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- step_cw  in  NUM_DIALS  per-dial increment request
- step_ccw  in  NUM_DIALS  per-dial decrement request
- prog_wr  in  1  load combination strobe
- code_in  in  NUM_DIALS*DIAL_W  packed combination, dial 0 in LSBs
- enter  in  1  attempt-unlock strobe
- relock  in  1  return-to-locked strobe
- dial_val  out  NUM_DIALS*DIAL_W  packed current dial values
- unlocked  out  1  high while in OPEN
- fail_pulse  out  1  one-cycle pulse per failed attempt
- lockout  out  1  high while in LOCKOUT
- fail_cnt  out  4  consecutive failures
- state  out  3  FSM state encoding

Function
REQ-008 The FSM SHALL have states IDLE=0, CHECK=1, OPEN=2, FAIL=3, LOCKOUT=4.
REQ-009 In IDLE, on each edge, each dial SHALL increment if only step_cw[i] is high, decrement if only step_ccw[i] is high, and hold if both or neither are high.
REQ-010 Dials SHALL wrap DIAL_MAX->0 on increment and 0->DIAL_MAX on decrement.
REQ-011 Dials SHALL ignore step inputs outside IDLE.
REQ-012 prog_wr SHALL load code_in into the code register only in IDLE or OPEN, and SHALL be ignored otherwise.
REQ-013 A code digit greater than DIAL_MAX SHALL be stored unchanged and shall never match.
REQ-014 enter in IDLE SHALL move to CHECK; enter in other states SHALL be ignored.
REQ-015 If enter and prog_wr are both high in IDLE, the write SHALL take effect first, and CHECK SHALL compare against the new code.
REQ-016 CHECK SHALL last exactly one cycle, comparing all dials to all code digits: all equal -> OPEN, otherwise -> FAIL.
REQ-017 unlocked SHALL assert 2 cycles after the edge on which enter is sampled.
REQ-018 On entering OPEN, fail_cnt SHALL clear to 0.
REQ-019 OPEN SHALL persist until relock; relock SHALL move to IDLE and clear all dials to 0.
REQ-020 FAIL SHALL last one cycle: fail_pulse=1, fail_cnt increments (saturating at MAX_TRIES), and all dials clear to 0.
REQ-021 The next state after FAIL SHALL be IDLE, except as stated in REQ-027.
REQ-022 If enter and relock are both high in the same cycle, each SHALL act only in its own state, so no conflict arises.

Reset
REQ-023 RST SHALL force IDLE, all dials=0, code register=0, and fail_cnt=0.
REQ-024 RST SHALL force the outputs unlocked=0, fail_pulse=0, lockout=0, and state=0.
REQ-025 RST SHALL clear the lockout timer.
REQ-026 RST SHALL take priority over every input in every state, including mid-CHECK and mid-LOCKOUT.

Configuration
REQ-027 With macro COMBO_LOCKOUT_EN defined, a FAIL that brings fail_cnt to MAX_TRIES SHALL go to LOCKOUT.
REQ-028 LOCKOUT SHALL hold lockout=1 for exactly LOCKOUT_CYCLES cycles, ignoring enter, prog_wr, and step inputs, then go to IDLE with fail_cnt=0.
REQ-029 Without COMBO_LOCKOUT_EN, LOCKOUT SHALL be unreachable, lockout SHALL be tied 0, no lockout timer SHALL be built, and fail_cnt SHALL saturate at MAX_TRIES.

Verification (defaults)
REQ-030 The bench SHALL cover: code=(4,7,12), dials stepped to (4,7,12), enter -> unlocked=1 two cycles later, fail_cnt=0.
REQ-031 The bench SHALL cover: dial0 at 19 with step_cw -> 0; dial0 at 0 with step_ccw -> 19; step_cw and step_ccw together -> value unchanged.
REQ-032 The bench SHALL cover: dials (4,7,11), enter -> fail_pulse for one cycle 2 cycles after enter, fail_cnt=1, dials (0,0,0), state IDLE.
REQ-033 The bench SHALL cover (macro on): three wrong attempts -> lockout=1 for 16 cycles, enter ignored throughout, then IDLE with fail_cnt=0; macro off -> fail_cnt=3, lockout=0.
REQ-034 The bench SHALL cover: prog_wr with code (1,2,3) in the same cycle as enter, dials at (1,2,3) -> OPEN.
REQ-035 The bench SHALL cover: RST asserted in LOCKOUT or OPEN -> next cycle state=0, unlocked=0, lockout=0, dials 0.

Source files
------------

// File: rtl/combo_lock_core.sv
// rtl/combo_lock_core.sv - dial combination lock FSM; optional failed-attempt lockout via COMBO_LOCKOUT_EN
module combo_lock_core #(
    parameter int NUM_DIALS      = 3,
    parameter int DIAL_W         = 5,
    parameter int DIAL_MAX       = 19,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_DIALS-1:0]        step_cw,
    input  logic [NUM_DIALS-1:0]        step_ccw,
    input  logic                        prog_wr,
    input  logic [NUM_DIALS*DIAL_W-1:0] code_in,
    input  logic                        enter,
    input  logic                        relock,
    output logic [NUM_DIALS*DIAL_W-1:0] dial_val,
    output logic                        unlocked,
    output logic                        fail_pulse,
    output logic                        lockout,
    output logic [3:0]                  fail_cnt,
    output logic [2:0]                  state
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CHECK   = 3'd1;
    localparam logic [2:0] ST_OPEN    = 3'd2;
    localparam logic [2:0] ST_FAIL    = 3'd3;
    localparam logic [2:0] ST_LOCKOUT = 3'd4;

    localparam logic [DIAL_W-1:0] DIAL_MAX_V  = DIAL_W'(DIAL_MAX);
    localparam logic [3:0]        MAX_TRIES_V = 4'(MAX_TRIES);

    if (NUM_DIALS < 1 || NUM_DIALS > 8) begin : g_bad_num_dials
        $error("combo_lock_core: NUM_DIALS out of range");
    end
    if (DIAL_MAX < 0 || DIAL_MAX >= (1 << DIAL_W)) begin : g_bad_dial_max
        $error("combo_lock_core: DIAL_MAX does not fit in DIAL_W");
    end
    if (MAX_TRIES < 1 || MAX_TRIES > 15) begin : g_bad_max_tries
        $error("combo_lock_core: MAX_TRIES out of range");
    end
    if (LOCKOUT_CYCLES < 1) begin : g_bad_lockout_cycles
        $error("combo_lock_core: LOCKOUT_CYCLES must be at least 1");
    end

    logic [2:0]                  state_q;
    logic [NUM_DIALS*DIAL_W-1:0] dials_q;
    logic [NUM_DIALS*DIAL_W-1:0] code_q;
    logic [3:0]                  fail_cnt_q;

    logic [NUM_DIALS*DIAL_W-1:0] dials_step;
    logic [DIAL_W-1:0]           cur_dial;
    logic                        code_match;

    // Per-dial wrap-around stepping; simultaneous cw/ccw cancel out.
    always_comb begin
        dials_step = dials_q;
        cur_dial   = '0;
        for (int i = 0; i < NUM_DIALS; i++) begin
            cur_dial = dials_q[i*DIAL_W +: DIAL_W];
            if (step_cw[i] && !step_ccw[i]) begin
                dials_step[i*DIAL_W +: DIAL_W] = (cur_dial == DIAL_MAX_V) ? '0 : cur_dial + 1'b1;
            end else if (step_ccw[i] && !step_cw[i]) begin
                dials_step[i*DIAL_W +: DIAL_W] = (cur_dial == '0) ? DIAL_MAX_V : cur_dial - 1'b1;
            end
        end
    end

    // An out-of-range code digit can never be matched by a dial.
    always_comb begin
        code_match = 1'b1;
        for (int i = 0; i < NUM_DIALS; i++) begin
            if ((dials_q[i*DIAL_W +: DIAL_W] != code_q[i*DIAL_W +: DIAL_W]) ||
                (code_q[i*DIAL_W +: DIAL_W] > DIAL_MAX_V)) begin
                code_match = 1'b0;
            end
        end
    end

`ifdef COMBO_LOCKOUT_EN
    localparam int TMR_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);

    logic [TMR_W-1:0] lock_tmr_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            lock_tmr_q <= '0;
        end else if (state_q == ST_FAIL) begin
            lock_tmr_q <= TMR_LOAD;
        end else if (state_q == ST_LOCKOUT && lock_tmr_q != '0) begin
            lock_tmr_q <= lock_tmr_q - 1'b1;
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            dials_q    <= '0;
            code_q     <= '0;
            fail_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    dials_q <= dials_step;
                    if (prog_wr) begin
                        code_q <= code_in;
                    end
                    if (enter) begin
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (code_match) begin
                        state_q    <= ST_OPEN;
                        fail_cnt_q <= '0;
                    end else begin
                        state_q <= ST_FAIL;
                        dials_q <= '0;
                        if (fail_cnt_q < MAX_TRIES_V) begin
                            fail_cnt_q <= fail_cnt_q + 4'd1;
                        end
                    end
                end
                ST_OPEN: begin
                    if (prog_wr) begin
                        code_q <= code_in;
                    end
                    if (relock) begin
                        state_q <= ST_IDLE;
                        dials_q <= '0;
                    end
                end
                ST_FAIL: begin
`ifdef COMBO_LOCKOUT_EN
                    state_q <= (fail_cnt_q == MAX_TRIES_V) ? ST_LOCKOUT : ST_IDLE;
`else
                    state_q <= ST_IDLE;
`endif
                end
`ifdef COMBO_LOCKOUT_EN
                ST_LOCKOUT: begin
                    if (lock_tmr_q == '0) begin
                        state_q    <= ST_IDLE;
                        fail_cnt_q <= '0;
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dial_val   = dials_q;
    assign unlocked   = (state_q == ST_OPEN);
    assign fail_pulse = (state_q == ST_FAIL);
    assign fail_cnt   = fail_cnt_q;
    assign state      = state_q;
`ifdef COMBO_LOCKOUT_EN
    assign lockout    = (state_q == ST_LOCKOUT);
`else
    assign lockout    = 1'b0;
`endif

endmodule

// File: tb/tb_combo_lock_core.sv
// tb/tb_combo_lock_core.sv - directed self-checking bench for combo_lock_core (default parameters)
module tb_combo_lock_core;

    logic        CLK = 1'b0;
    logic        RST;
    logic [2:0]  step_cw;
    logic [2:0]  step_ccw;
    logic        prog_wr;
    logic [14:0] code_in;
    logic        enter;
    logic        relock;
    logic [14:0] dial_val;
    logic        unlocked;
    logic        fail_pulse;
    logic        lockout;
    logic [3:0]  fail_cnt;
    logic [2:0]  state;

    int n_checks = 0;
    int n_pass   = 0;

    combo_lock_core dut (
        .CLK        (CLK),
        .RST        (RST),
        .step_cw    (step_cw),
        .step_ccw   (step_ccw),
        .prog_wr    (prog_wr),
        .code_in    (code_in),
        .enter      (enter),
        .relock     (relock),
        .dial_val   (dial_val),
        .unlocked   (unlocked),
        .fail_pulse (fail_pulse),
        .lockout    (lockout),
        .fail_cnt   (fail_cnt),
        .state      (state)
    );

    always #5 CLK = ~CLK;

    function automatic logic [14:0] dials3(input int d0, input int d1, input int d2);
        return {5'(d2), 5'(d1), 5'(d0)};
    endfunction

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wrong_attempt();
        step_cw = 3'b001;
        tick();
        step_cw = 3'b000;
        enter = 1'b1;
        tick();
        enter = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        RST = 1'b1; step_cw = '0; step_ccw = '0; prog_wr = 1'b0;
        code_in = '0; enter = 1'b0; relock = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_unlocked", unlocked, 0);
        chk("rst_lockout", lockout, 0);
        chk("rst_fail_pulse", fail_pulse, 0);
        chk("rst_fail_cnt", fail_cnt, 0);
        chk("rst_dials", dial_val, 0);

        // wrap and cancel behaviour on dial 0
        step_ccw = 3'b001;
        tick();
        chk("wrap_ccw", dial_val, dials3(19, 0, 0));
        step_cw = 3'b001;
        tick();
        chk("cw_ccw_hold", dial_val, dials3(19, 0, 0));
        step_ccw = 3'b000;
        tick();
        chk("wrap_cw", dial_val, dials3(0, 0, 0));
        step_cw = 3'b000;

        // program (4,7,12), dial it in, open
        code_in = dials3(4, 7, 12);
        prog_wr = 1'b1;
        tick();
        prog_wr = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step_cw = {k < 12, k < 7, k < 4};
            tick();
        end
        step_cw = 3'b000;
        chk("dials_4_7_12", dial_val, dials3(4, 7, 12));
        enter = 1'b1;
        tick();
        enter = 1'b0;
        chk("check_state", state, 1);
        chk("check_unlocked", unlocked, 0);
        tick();
        chk("open_state", state, 2);
        chk("open_unlocked", unlocked, 1);
        chk("open_fail_cnt", fail_cnt, 0);
        relock = 1'b1;
        tick();
        relock = 1'b0;
        chk("relock_state", state, 0);
        chk("relock_dials", dial_val, 0);
        chk("relock_unlocked", unlocked, 0);

        // wrong combination (4,7,11)
        for (int k = 0; k < 11; k++) begin
            step_cw = {k < 11, k < 7, k < 4};
            tick();
        end
        step_cw = 3'b000;
        chk("dials_4_7_11", dial_val, dials3(4, 7, 11));
        enter = 1'b1;
        tick();
        enter = 1'b0;
        chk("fail_not_yet", fail_pulse, 0);
        tick();
        chk("fail_pulse", fail_pulse, 1);
        chk("fail_state", state, 3);
        chk("fail_cnt_1", fail_cnt, 1);
        chk("fail_dials", dial_val, 0);
        tick();
        chk("fail_pulse_end", fail_pulse, 0);
        chk("after_fail_state", state, 0);
        chk("after_fail_cnt", fail_cnt, 1);

        // two more wrong attempts with dials at (0,0,0)
        enter = 1'b1;
        tick();
        enter = 1'b0;
        tick();
        chk("fail_cnt_2", fail_cnt, 2);
        tick();
        enter = 1'b1;
        tick();
        enter = 1'b0;
        tick();
        chk("fail3_pulse", fail_pulse, 1);
        chk("fail_cnt_3", fail_cnt, 3);
        tick();
`ifdef COMBO_LOCKOUT_EN
        enter = 1'b1;
        step_cw = 3'b111;
        for (int i = 0; i < 16; i++) begin
            chk("lockout_hold", lockout, 1);
            chk("lockout_state", state, 4);
            chk("lockout_dials", dial_val, 0);
            if (i == 15) begin
                enter = 1'b0;
                step_cw = 3'b000;
            end
            tick();
        end
        chk("lockout_exit_state", state, 0);
        chk("lockout_exit_flag", lockout, 0);
        chk("lockout_exit_cnt", fail_cnt, 0);
`else
        chk("nolock_state", state, 0);
        chk("nolock_lockout", lockout, 0);
        chk("nolock_cnt", fail_cnt, 3);
        enter = 1'b1;
        tick();
        enter = 1'b0;
        tick();
        chk("sat_cnt", fail_cnt, 3);
        chk("sat_lockout", lockout, 0);
        tick();
`endif

        // write and enter together: new code (1,2,3) is compared
        for (int k = 0; k < 3; k++) begin
            step_cw = {k < 3, k < 2, k < 1};
            tick();
        end
        step_cw = 3'b000;
        code_in = dials3(1, 2, 3);
        prog_wr = 1'b1;
        enter = 1'b1;
        tick();
        prog_wr = 1'b0;
        enter = 1'b0;
        tick();
        chk("wr_enter_open", state, 2);
        chk("wr_enter_unlocked", unlocked, 1);
        chk("wr_enter_cnt", fail_cnt, 0);

        // reset while open
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("rst_open_state", state, 0);
        chk("rst_open_unlocked", unlocked, 0);
        chk("rst_open_lockout", lockout, 0);
        chk("rst_open_dials", dial_val, 0);

        // code register cleared: dials (0,0,0) now open
        enter = 1'b1;
        tick();
        enter = 1'b0;
        tick();
        chk("zero_code_open", state, 2);
        relock = 1'b1;
        tick();
        relock = 1'b0;

        // reset mid-CHECK
        step_cw = 3'b001;
        tick();
        step_cw = 3'b000;
        enter = 1'b1;
        tick();
        enter = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("rst_check_state", state, 0);
        chk("rst_check_pulse", fail_pulse, 0);
        chk("rst_check_cnt", fail_cnt, 0);

`ifdef COMBO_LOCKOUT_EN
        wrong_attempt();
        wrong_attempt();
        wrong_attempt();
        chk("relock_lockout", state, 4);
        tick();
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("rst_lock_state", state, 0);
        chk("rst_lock_flag", lockout, 0);
        chk("rst_lock_cnt", fail_cnt, 0);
        chk("rst_lock_dials", dial_val, 0);
`else
        wrong_attempt();
        chk("post_rst_fail_cnt", fail_cnt, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
